// File: rtl/fetcher_pkg.sv
// rtl/fetcher_pkg.sv - shared widths, encodings and queue entry type for the fetcher
package fetcher_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstBus-1:0]     NOP_INST = 32'h0000_0013;
    localparam logic [InstAddrBus-1:0] PC_STEP  = 32'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_KILL = 2'd2;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } iq_entry_t;

endpackage

// File: rtl/fetcher_inst_queue.sv
// rtl/fetcher_inst_queue.sv - synchronous FIFO of {pc, inst} pairs with single-cycle flush
module fetcher_inst_queue
    import fetcher_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  iq_entry_t              i_data,
    output iq_entry_t              o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);

    iq_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage needs no reset; validity is tracked entirely by r_count.
    always_ff @(posedge clk) begin
        if (w_do_push && !rst && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetcher.sv
// rtl/fetcher.sv - instruction fetch unit: one outstanding memory request, instruction queue, decoder output stage
module fetcher
    import fetcher_pkg::*;
#(
    parameter int                     IQ_DEPTH = 4,
    parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   misTaken,
    input  logic [InstAddrBus-1:0] jumpAddr,
    output logic                   memReq,
    output logic [InstAddrBus-1:0] memAddr,
    input  logic                   memReady,
    input  logic                   memValid,
    input  logic [InstBus-1:0]     memData,
    output logic [InstAddrBus-1:0] instPC,
    output logic [InstBus-1:0]     inst,
    output logic                   DecEn
);

    localparam int CW = $clog2(IQ_DEPTH) + 1;

    logic [1:0]             r_state;
    logic [InstAddrBus-1:0] r_fetch_pc;
    logic [InstAddrBus-1:0] r_inst_pc;
    logic [InstBus-1:0]     r_inst;
    logic                   r_dec_en;

    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    iq_entry_t     w_push_entry;
    iq_entry_t     w_iq_head;
    logic          w_iq_full;
    logic          w_iq_empty;
    logic [CW-1:0] w_iq_count;

    assign memReq  = (r_state == ST_IDLE) & ~rst & ~misTaken & (w_iq_count < CW'(IQ_DEPTH));
    assign memAddr = r_fetch_pc;
    assign w_issue = memReq & memReady;

    // fetchPC already advanced at accept time, so the returning word belongs to fetchPC-4.
    assign w_push       = (r_state == ST_WAIT) & memValid & ~misTaken & ~w_iq_full;
    assign w_push_entry = '{pc: r_fetch_pc - PC_STEP, inst: memData};
    assign w_pop        = ~stall & ~misTaken & ~w_iq_empty;

    fetcher_inst_queue #(
        .DEPTH(IQ_DEPTH)
    ) u_inst_queue (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_flush(misTaken),
        .i_data (w_push_entry),
        .o_head (w_iq_head),
        .o_full (w_iq_full),
        .o_empty(w_iq_empty),
        .o_count(w_iq_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
        end else begin
            if (misTaken) begin
                r_fetch_pc <= jumpAddr;
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
            end

            case (r_state)
                ST_IDLE: if (w_issue) r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (memValid) begin
                        r_state <= ST_IDLE;
                    end else if (misTaken) begin
                        r_state <= ST_KILL;
                    end
                end
                ST_KILL: if (memValid) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst_pc <= '0;
            r_inst    <= '0;
            r_dec_en  <= 1'b0;
        end else if (misTaken) begin
            r_dec_en <= 1'b0;
        end else if (!stall) begin
            if (!w_iq_empty) begin
                r_inst_pc <= w_iq_head.pc;
                r_inst    <= w_iq_head.inst;
                r_dec_en  <= 1'b1;
            end else begin
                r_dec_en <= 1'b0;
            end
        end
    end

    assign instPC = r_inst_pc;
    assign inst   = r_inst;
    assign DecEn  = r_dec_en;

endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 Parameter IQ_DEPTH, default 4, instruction-queue entries; power of two, at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  in  1  clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 stall  in  1  decoder/dispatcher cannot accept; decoded slot held.
REQ-006 misTaken  in  1  branch mispredict/redirect, single-cycle pulse.
REQ-007 jumpAddr  in  32  redirect target, valid with misTaken.
REQ-008 memReq  out  1  fetch request to memory controller (combinational).
REQ-009 memAddr  out  32  word address of request, valid with memReq.
REQ-010 memReady  in  1  controller accepts request this cycle.
REQ-011 memValid  in  1  read data returned this cycle.
REQ-012 memData  in  32  returned instruction word.
REQ-013 instPC  out  32  PC of instruction presented to decoder (registered).
REQ-014 inst  out  32  instruction word presented to decoder (registered).
REQ-015 DecEn  out  1  instPC/inst valid; consumed when DecEn & ~stall.

Function
REQ-016 FSM states: IDLE (no request outstanding), WAIT (one accepted, awaiting data), KILL (accepted request's data to be discarded).
REQ-017 memReq = (state==IDLE) & ~rst & ~misTaken & (count < IQ_DEPTH); memAddr = fetchPC.
REQ-018 memReq & memReady: fetchPC <= fetchPC + 4 (mod 2^32), IDLE -> WAIT.
REQ-019 memReq & ~memReady: memReq and memAddr held unchanged next cycle, unless misTaken.
REQ-020 WAIT & memValid & ~misTaken: push {fetchPC-4, memData} into queue, WAIT -> IDLE.
REQ-021 KILL & memValid: data dropped, KILL -> IDLE; memValid in IDLE ignored.
REQ-022 At most one request outstanding at any time.
REQ-023 Output stage, ~stall & queue non-empty: instPC/inst <= head, DecEn <= 1, head popped.
REQ-024 Output stage, ~stall & queue empty: DecEn <= 0; instPC/inst keep value.
REQ-025 stall: instPC, inst, DecEn held; no pop.
REQ-026 Latency: memValid at cycle t -> DecEn high in cycle t+2 when queue empty and no stall.
REQ-027 Push and pop in the same cycle both happen; count unchanged.
REQ-028 Push never occurs when full (guaranteed by REQ-017); queue pointers wrap modulo IQ_DEPTH.
REQ-029 misTaken: queue flushed (count 0), DecEn <= 0, fetchPC <= jumpAddr, regardless of stall.
REQ-030 misTaken in WAIT without memValid: WAIT -> KILL; with memValid: data dropped, -> IDLE.
REQ-031 misTaken in KILL: stays KILL unless memValid (-> IDLE); fetchPC <= jumpAddr.
REQ-032 misTaken has priority over push, pop and request issue in the same cycle.

Reset
REQ-033 rst: state IDLE, fetchPC <= RESET_PC, queue empty, DecEn 0, instPC 0, inst 0.
REQ-034 memReq 0 during rst; rst mid-WAIT discards the late response (memValid in IDLE ignored).
REQ-035 First request issued in the first cycle after rst deasserts.

Structure
REQ-036 Shared package: InstAddrBus/InstBus widths (32), NOP encoding 32'h0000_0013, FSM state encoding, PC step 4.
REQ-037 One sub-module: inst_queue, synchronous FIFO (push, pop, flush, full, empty, count) of {pc, inst} pairs.

Verification
REQ-038 Reset, memReady=1, memValid one cycle after accept, data 32'h00A00093 -> memAddr 0,4,8...; first DecEn with instPC 0, inst 32'h00A00093.
REQ-039 stall held 10 cycles, IQ_DEPTH=4 -> exactly 4 words queued, memReq 0, DecEn/inst held; release -> PCs 0,4,8,12,16 in order, no gaps.
REQ-040 memReady low 3 cycles -> memReq/memAddr stable; accept on 4th cycle, single fetchPC increment.
REQ-041 misTaken, jumpAddr 32'h0000_1000, while WAIT -> next memValid data dropped; next request address 32'h1000; no pre-redirect PC reaches DecEn.
REQ-042 misTaken coincident with memValid and full queue -> data dropped, queue empty, DecEn 0 next cycle, fetch resumes at jumpAddr.
REQ-043 rst pulse in WAIT, stale memValid next cycle -> ignored; refetch from RESET_PC.
